// File: rtl/ovc_alloc_port_if.sv
// Request/grant and per-OVC status bundle between the input-VC stages and
// the output-VC allocator of one router output port.
interface ovc_alloc_port_if #(
  parameter int V = 4,
  parameter int R = 4
);
  logic [R-1:0]   req;
  logic [R*V-1:0] req_ovc_mask;
  logic [R-1:0]   grant;
  logic [V-1:0]   grant_ovc;
  // "release" is a reserved word, so the tail-flit return strobe is ovc_release
  logic [V-1:0]   ovc_release;
  logic [V-1:0]   flit_sent;
  logic [V-1:0]   credit_in;
  logic [V-1:0]   ovc_busy;
  logic [V-1:0]   ovc_has_credit;
  logic           credit_err;

  modport master (
    output req, req_ovc_mask, ovc_release, flit_sent, credit_in,
    input  grant, grant_ovc, ovc_busy, ovc_has_credit, credit_err
  );

  modport slave (
    input  req, req_ovc_mask, ovc_release, flit_sent, credit_in,
    output grant, grant_ovc, ovc_busy, ovc_has_credit, credit_err
  );
endinterface

// File: rtl/ovc_alloc_port.sv
// Output-VC allocator: round-robin over requesters, lowest free credited OVC,
// with per-OVC ownership and downstream credit tracking.
module ovc_alloc_port #(
  parameter int V = 4,
  parameter int R = 4,
  parameter int B = 4
) (
  input  logic            clk,
  input  logic            reset,
  ovc_alloc_port_if.slave bus
);
  localparam int Bw = $clog2(B + 1);
  localparam int Pw = (R > 1) ? $clog2(R) : 1;

  typedef enum logic {FREE = 1'b0, ALLOC = 1'b1} ovc_state_t;

  ovc_state_t     state_q  [V];
  ovc_state_t     state_d  [V];
  logic [Bw-1:0]  credit_q [V];
  logic [Bw-1:0]  credit_d [V];
  logic [Pw-1:0]  ptr_q, ptr_d;
  logic [R-1:0]   grant_q, grant_d;
  logic [V-1:0]   grant_ovc_q, grant_ovc_d;
  logic           err_q, err_d;

  logic [V-1:0]   eligible;
  logic [V-1:0]   mask_eff [R];
  logic [R-1:0]   active;
  logic           found;
  int             winner;
  int             idx;
  logic [V-1:0]   sel;
  logic [V-1:0]   ovc_pick;

  // Eligibility looks only at registered state, so same-cycle release or
  // credit return takes effect one cycle later.
  always_comb begin
    for (int v = 0; v < V; v++) begin
      eligible[v] = (state_q[v] == FREE) && (credit_q[v] != '0);
    end
    for (int r = 0; r < R; r++) begin
      mask_eff[r] = (V == 1) ? '1 : bus.req_ovc_mask[r*V +: V];
      active[r]   = bus.req[r] & ~grant_q[r] & (|(mask_eff[r] & eligible));
    end
  end

  always_comb begin
    found  = 1'b0;
    winner = 0;
    idx    = 0;
    for (int k = 0; k < R; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= R) idx = idx - R;
      if (!found && active[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
    sel      = mask_eff[winner] & eligible;
    ovc_pick = sel & (~sel + V'(1));

    grant_d = '0;
    if (found) grant_d[winner] = 1'b1;
    grant_ovc_d = found ? ovc_pick : '0;

    if (found) ptr_d = (winner + 1 >= R) ? '0 : Pw'(winner + 1);
    else       ptr_d = ptr_q;
  end

  // Ownership and credit next-state; misuse of credits saturates and latches the error.
  always_comb begin
    err_d = err_q;
    for (int v = 0; v < V; v++) begin
      state_d[v] = state_q[v];
      if (bus.ovc_release[v]) state_d[v] = FREE;
      if (found && ovc_pick[v]) state_d[v] = ALLOC;

      credit_d[v] = credit_q[v];
      case ({bus.credit_in[v], bus.flit_sent[v]})
        2'b10: begin
          if (credit_q[v] == Bw'(B)) err_d = 1'b1;
          else                       credit_d[v] = credit_q[v] + Bw'(1);
        end
        2'b01: begin
          if (credit_q[v] == '0) err_d = 1'b1;
          else                   credit_d[v] = credit_q[v] - Bw'(1);
        end
        default: credit_d[v] = credit_q[v];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int v = 0; v < V; v++) begin
        state_q[v]  <= FREE;
        credit_q[v] <= Bw'(B);
      end
      ptr_q       <= '0;
      grant_q     <= '0;
      grant_ovc_q <= '0;
      err_q       <= 1'b0;
    end else begin
      for (int v = 0; v < V; v++) begin
        state_q[v]  <= state_d[v];
        credit_q[v] <= credit_d[v];
      end
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      grant_ovc_q <= grant_ovc_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    for (int v = 0; v < V; v++) begin
      bus.ovc_busy[v]       = (state_q[v] == ALLOC);
      bus.ovc_has_credit[v] = (credit_q[v] != '0);
    end
    bus.grant      = grant_q;
    bus.grant_ovc  = grant_ovc_q;
    bus.credit_err = err_q;
  end
endmodule
